mul_ctrl: RTL

// - Control unit for the repeated-addition multiplier. It drives the load and clear strobes of the

---
 rtl/mul_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mul_ctrl.sv
// Control FSM for the repeated-addition multiplier: sequences operand loads, product clear and the add/decrement loop.
// Optional iteration timeout is compiled in with MUL_TIMEOUT_EN (err flags a run cut short at MAX_ITER adds).
module mul_ctrl #(
    parameter int ITER_W   = 16,
    parameter int MAX_ITER = 65535
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              eqz,
    output logic              ldA,
    output logic              ldB,
    output logic              clrP,
    output logic              ldP,
    output logic              decB,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] iters,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        ADD    = 3'd3,
        DONE   = 3'd4
    } state_t;

    if (ITER_W < 1 || ITER_W > 31 || MAX_ITER < 1 || MAX_ITER > (2 ** ITER_W) - 1) begin : g_bad_params
        $error("mul_ctrl: MAX_ITER must fit in ITER_W bits and be non-zero");
    end

    state_t            state_r;
    state_t            next_state_s;
    logic [ITER_W-1:0] iters_r;
    logic [ITER_W-1:0] next_iters_s;
    logic              limit_hit_s;

`ifdef MUL_TIMEOUT_EN
    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

    logic err_r;

    assign limit_hit_s = (iters_r == ITER_LIMIT);
    assign err         = err_r;

    // Timeout flag: set when the add loop is cut short, cleared by the next operand load
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            err_r <= 1'b0;
        end else if (state_r == LOAD_B) begin
            err_r <= 1'b0;
        end else if (state_r == ADD && !eqz && limit_hit_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end
`else
    assign limit_hit_s = 1'b0;
    assign err         = 1'b0;
`endif

    assign iters = iters_r;

    // State and iteration counter registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= IDLE;
            iters_r <= {ITER_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            iters_r <= next_iters_s;
        end
    end

    // Next-state and strobe decode; strobes follow the state so clr silences them at once
    always_comb begin
        next_state_s = state_r;
        next_iters_s = iters_r;
        ldA          = 1'b0;
        ldB          = 1'b0;
        clrP         = 1'b0;
        ldP          = 1'b0;
        decB         = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (state_r)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state_s = LOAD_A;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD_A: begin
                ldA          = 1'b1;
                next_state_s = LOAD_B;
            end
            LOAD_B: begin
                ldB          = 1'b1;
                clrP         = 1'b1;
                next_iters_s = {ITER_W{1'b0}};
                next_state_s = ADD;
            end
            ADD: begin
                if (eqz) begin
                    next_state_s = DONE;
                end else if (limit_hit_s) begin
                    next_state_s = DONE;
                end else begin
                    ldP          = 1'b1;
                    decB         = 1'b1;
                    next_iters_s = iters_r + ITER_W'(1);
                    next_state_s = ADD;
                end
            end
            DONE: begin
                done = 1'b1;
                // Level-sensitive start: wait for it to drop before accepting another run
                if (start) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: begin
                busy         = 1'b0;
                next_state_s = IDLE;
            end
        endcase
    end

endmodule
